// File: rtl/tankwar_pkg.sv
// Shared tank-war video definitions: colour type, backdrop colour and default
// layer priorities (bullet above tanks above background).
package tankwar_pkg;

    localparam int COLOR_W_DEF = 12;

    typedef logic [COLOR_W_DEF-1:0] color_t;

    localparam color_t BLACK = 12'h000;

    typedef enum logic [1:0] {
        LAYER_BULLET     = 2'd0,
        LAYER_TANK1      = 2'd1,
        LAYER_TANK2      = 2'd2,
        LAYER_BACKGROUND = 2'd3
    } layer_id_t;

    localparam logic [1:0] PRIO_BULLET     = 2'd0;
    localparam logic [1:0] PRIO_TANK1      = 2'd1;
    localparam logic [1:0] PRIO_TANK2      = 2'd2;
    localparam logic [1:0] PRIO_BACKGROUND = 2'd3;

endpackage

// File: rtl/layer_prio_arbiter.sv
// Combinational arg-min over (priority, index) of the active layers; a strict
// less-than keeps the lowest index on duplicate priorities.
module layer_prio_arbiter
    import tankwar_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    localparam int PRIO_W = $clog2(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0]        on_i,
    input  logic [NUM_LAYERS*PRIO_W-1:0] prio_i,
    output logic                         valid_o,
    output logic [PRIO_W-1:0]            idx_o
);

    logic              found_s;
    logic              take_s;
    logic [PRIO_W-1:0] idx_s;
    logic [PRIO_W-1:0] best_s;

    // Linear scan keeping the best candidate seen so far.
    always_comb begin
        found_s = 1'b0;
        take_s  = 1'b0;
        idx_s   = '0;
        best_s  = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            take_s  = on_i[i] & (~found_s | (prio_i[i*PRIO_W +: PRIO_W] < best_s));
            idx_s   = take_s ? PRIO_W'(i) : idx_s;
            best_s  = take_s ? prio_i[i*PRIO_W +: PRIO_W] : best_s;
            found_s = found_s | take_s;
        end
    end

    assign valid_o = found_s;
    assign idx_o   = idx_s;

endmodule

// File: rtl/layer_compositor.sv
// Two-stage layer compositor with frame-synchronous priority/enable registers.
// Define TANKWAR_COLLISION_EN to build the per-frame layer-overlap reporting.
module layer_compositor
    import tankwar_pkg::*;
#(
    parameter int                 NUM_LAYERS = 4,
    parameter int                 COLOR_W    = COLOR_W_DEF,
    parameter logic [COLOR_W-1:0] BACKDROP   = COLOR_W'(BLACK),
    localparam int                PRIO_W     = $clog2(NUM_LAYERS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             video_on,
    input  logic                             frame_start,
    input  logic [NUM_LAYERS-1:0]            layer_on,
    input  logic [NUM_LAYERS*COLOR_W-1:0]    layer_color,
    input  logic                             cfg_we,
    input  logic [PRIO_W-1:0]                cfg_layer,
    input  logic [PRIO_W-1:0]                cfg_prio,
    input  logic                             cfg_en,
    output logic [COLOR_W-1:0]               rgb,
    output logic                             rgb_valid,
    output logic [NUM_LAYERS*NUM_LAYERS-1:0] collision,
    output logic                             collision_valid
);

    logic [NUM_LAYERS*PRIO_W-1:0]  sh_prio_q, sh_prio_d, act_prio_q, act_prio_d;
    logic [NUM_LAYERS-1:0]         sh_en_q, sh_en_d, act_en_q, act_en_d;
    logic [NUM_LAYERS-1:0]         on_q, on_d;
    logic [NUM_LAYERS*COLOR_W-1:0] col_q;
    logic                          vid_q;
    logic [COLOR_W-1:0]            rgb_q, rgb_d;
    logic                          rgb_valid_q;
    logic                          cvalid_q;
    logic                          win_valid_s;
    logic [PRIO_W-1:0]             win_idx_s;

    // Shadow update; an out-of-range layer index leaves the shadow set untouched.
    always_comb begin
        if (cfg_we && (int'(cfg_layer) < NUM_LAYERS)) begin
            sh_prio_d = sh_prio_q;
            sh_en_d   = sh_en_q;
            sh_prio_d[int'(cfg_layer)*PRIO_W +: PRIO_W] = cfg_prio;
            sh_en_d[cfg_layer] = cfg_en;
        end else begin
            sh_prio_d = sh_prio_q;
            sh_en_d   = sh_en_q;
        end
    end

    // Copying the next shadow value makes a same-cycle write take effect.
    assign act_prio_d = frame_start ? sh_prio_d : act_prio_q;
    assign act_en_d   = frame_start ? sh_en_d   : act_en_q;
    assign on_d       = layer_on & act_en_q & {NUM_LAYERS{video_on}};

    // Configuration registers, defaulting to prio[i]=i with all layers enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                sh_prio_q[i*PRIO_W +: PRIO_W]  <= PRIO_W'(i);
                act_prio_q[i*PRIO_W +: PRIO_W] <= PRIO_W'(i);
            end
            sh_en_q  <= '1;
            act_en_q <= '1;
        end else begin
            sh_prio_q  <= sh_prio_d;
            sh_en_q    <= sh_en_d;
            act_prio_q <= act_prio_d;
            act_en_q   <= act_en_d;
        end
    end

    layer_prio_arbiter #(
        .NUM_LAYERS (NUM_LAYERS)
    ) u_arb (
        .on_i    (on_q),
        .prio_i  (act_prio_q),
        .valid_o (win_valid_s),
        .idx_o   (win_idx_s)
    );

    // Stage-2 colour selection: blanking forces black, no layer gives backdrop.
    always_comb begin
        if (!vid_q) begin
            rgb_d = '0;
        end else if (win_valid_s) begin
            rgb_d = col_q[int'(win_idx_s)*COLOR_W +: COLOR_W];
        end else begin
            rgb_d = BACKDROP;
        end
    end

    // Pixel pipeline: stage 1 captures inputs, stage 2 holds the output pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            on_q        <= '0;
            col_q       <= '0;
            vid_q       <= 1'b0;
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            cvalid_q    <= 1'b0;
        end else begin
            on_q        <= on_d;
            col_q       <= layer_color;
            vid_q       <= video_on;
            rgb_q       <= rgb_d;
            rgb_valid_q <= vid_q;
            cvalid_q    <= frame_start;
        end
    end

`ifdef TANKWAR_COLLISION_EN
    logic [NUM_LAYERS*NUM_LAYERS-1:0] pair_s, acc_q, coll_q;

    // Upper-triangle overlap terms of the current stage-1 pixel.
    always_comb begin
        pair_s = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            for (int j = i + 1; j < NUM_LAYERS; j++) begin
                pair_s[i*NUM_LAYERS+j] = on_q[i] & on_q[j];
            end
        end
    end

    // Frame accumulator; frame_start publishes it including this cycle's terms.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            coll_q <= '0;
        end else if (frame_start) begin
            acc_q  <= '0;
            coll_q <= acc_q | pair_s;
        end else begin
            acc_q  <= acc_q | pair_s;
        end
    end

    assign collision = coll_q;
`else
    assign collision = '0;
`endif

    assign rgb             = rgb_q;
    assign rgb_valid       = rgb_valid_q;
    assign collision_valid = cvalid_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed self-checking bench for layer_compositor (default parameters).
module tb_layer_compositor;

    localparam int N  = 4;
    localparam int CW = 12;

    logic            clk = 1'b0;
    logic            reset;
    logic            video_on;
    logic            frame_start;
    logic [N-1:0]    layer_on;
    logic [N*CW-1:0] layer_color;
    logic            cfg_we;
    logic [1:0]      cfg_layer;
    logic [1:0]      cfg_prio;
    logic            cfg_en;
    logic [CW-1:0]   rgb;
    logic            rgb_valid;
    logic [N*N-1:0]  collision;
    logic            collision_valid;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_coll;

    always #5 clk = ~clk;

    layer_compositor dut (
        .clk             (clk),
        .reset           (reset),
        .video_on        (video_on),
        .frame_start     (frame_start),
        .layer_on        (layer_on),
        .layer_color     (layer_color),
        .cfg_we          (cfg_we),
        .cfg_layer       (cfg_layer),
        .cfg_prio        (cfg_prio),
        .cfg_en          (cfg_en),
        .rgb             (rgb),
        .rgb_valid       (rgb_valid),
        .collision       (collision),
        .collision_valid (collision_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] lay, input logic [1:0] pr, input logic en);
        cfg_we    = 1'b1;
        cfg_layer = lay;
        cfg_prio  = pr;
        cfg_en    = en;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Blank for two cycles to drain the pipe, then pulse frame_start (optionally with a write).
    task automatic frame_pulse(input logic we, input logic [1:0] lay, input logic [1:0] pr,
                               input logic en);
        video_on = 1'b0;
        layer_on = 4'b0000;
        repeat (2) @(negedge clk);
        frame_start = 1'b1;
        cfg_we      = we;
        cfg_layer   = lay;
        cfg_prio    = pr;
        cfg_en      = en;
        @(negedge clk);
        frame_start = 1'b0;
        cfg_we      = 1'b0;
    endtask

    task automatic show(input logic [3:0] on);
        video_on = 1'b1;
        layer_on = on;
        repeat (2) @(negedge clk);
    endtask

    initial begin
`ifdef TANKWAR_COLLISION_EN
        exp_coll = 16'h0004;
`else
        exp_coll = 16'h0000;
`endif
        reset       = 1'b1;
        video_on    = 1'b0;
        frame_start = 1'b0;
        layer_on    = 4'b0000;
        cfg_we      = 1'b0;
        cfg_layer   = 2'd0;
        cfg_prio    = 2'd0;
        cfg_en      = 1'b0;
        layer_color = {12'h0F0, 12'h0FF, 12'hF00, 12'h00F};
        repeat (2) @(negedge clk);
        chk("reset_rgb", 32'(rgb), 32'h0);
        chk("reset_valid", 32'(rgb_valid), 32'h0);
        chk("reset_coll", 32'(collision), 32'h0);
        chk("reset_cvalid", 32'(collision_valid), 32'h0);
        reset = 1'b0;

        show(4'b1010);
        chk("dflt_rgb", 32'(rgb), 32'hF00);
        chk("dflt_valid", 32'(rgb_valid), 32'h1);

        video_on = 1'b0;
        layer_on = 4'b1111;
        repeat (2) @(negedge clk);
        chk("blank_rgb", 32'(rgb), 32'h0);
        chk("blank_valid", 32'(rgb_valid), 32'h0);

        show(4'b0000);
        chk("backdrop_rgb", 32'(rgb), 32'h000);
        chk("backdrop_valid", 32'(rgb_valid), 32'h1);

        show(4'b1010);
        cfg_write(2'd3, 2'd0, 1'b1);
        cfg_write(2'd1, 2'd2, 1'b1);
        @(negedge clk);
        chk("prio_pending", 32'(rgb), 32'hF00);
        frame_pulse(1'b0, 2'd0, 2'd0, 1'b0);
        show(4'b1010);
        chk("prio_active", 32'(rgb), 32'h0F0);

        cfg_write(2'd0, 2'd1, 1'b1);
        cfg_write(2'd2, 2'd1, 1'b1);
        frame_pulse(1'b0, 2'd0, 2'd0, 1'b0);
        show(4'b0101);
        chk("tie_low_index", 32'(rgb), 32'h00F);

        frame_pulse(1'b1, 2'd0, 2'd1, 1'b0);
        show(4'b0101);
        chk("disable_through", 32'(rgb), 32'h0FF);

        frame_pulse(1'b1, 2'd0, 2'd1, 1'b1);
        video_on = 1'b1;
        layer_on = 4'b0101;
        @(negedge clk);
        layer_on = 4'b0010;
        @(negedge clk);
        chk("reenabled_tie", 32'(rgb), 32'h00F);
        layer_on = 4'b1000;
        @(negedge clk);
        layer_on = 4'b0010;
        @(negedge clk);
        layer_on = 4'b1000;
        @(negedge clk);
        frame_pulse(1'b0, 2'd0, 2'd0, 1'b0);
        chk("coll_value", 32'(collision), 32'(exp_coll));
        chk("coll_pulse", 32'(collision_valid), 32'h1);
        @(negedge clk);
        chk("coll_pulse_end", 32'(collision_valid), 32'h0);
        chk("coll_stable", 32'(collision), 32'(exp_coll));

        video_on = 1'b1;
        layer_on = 4'b0010;
        @(negedge clk);
        layer_on = 4'b1000;
        @(negedge clk);
        layer_on = 4'b0001;
        @(negedge clk);
        frame_pulse(1'b0, 2'd0, 2'd0, 1'b0);
        chk("coll_cleared", 32'(collision), 32'h0);
        chk("coll_pulse2", 32'(collision_valid), 32'h1);

        show(4'b0101);
        frame_pulse(1'b0, 2'd0, 2'd0, 1'b0);
        chk("coll_before_rst", 32'(collision), 32'(exp_coll));
        show(4'b0101);
        chk("rgb_before_rst", 32'(rgb), 32'h00F);
        #2 reset = 1'b1;
        #1;
        chk("async_rgb", 32'(rgb), 32'h0);
        chk("async_valid", 32'(rgb_valid), 32'h0);
        chk("async_coll", 32'(collision), 32'h0);
        chk("async_cvalid", 32'(collision_valid), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        frame_pulse(1'b0, 2'd0, 2'd0, 1'b0);
        chk("acc_discarded", 32'(collision), 32'h0);
        chk("post_rst_pulse", 32'(collision_valid), 32'h1);
        show(4'b1010);
        chk("post_rst_prio", 32'(rgb), 32'hF00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised, pipelined pixel compositor that merges up to NUM_LAYERS sprite/background layers into one RGB stream for `vgac`. It replaces the fixed bullet > tank1 > tank2 > background combinational mux with a runtime-programmable priority. Priority and enable updates are frame-synchronous, so a change never takes effect mid-frame. It also reports per-frame layer-overlap (collision) flags to `game_engine`.

## Interface
- NUM_LAYERS, 4, number of input layers (2..8)
- COLOR_W, 12, bits per pixel colour
- BACKDROP, 12'h000, colour output when video is on and no enabled layer is on
- PRIO_W, $clog2(NUM_LAYERS), derived; not overridden
---
- clk  in  1  pixel clock, rising edge; one clock domain only
- reset  in  1  asynchronous, active-high; clears all state
- video_on  in  1  active display region, aligned with the layer inputs
- frame_start  in  1  one-cycle pulse per frame, issued during blanking
- layer_on  in  NUM_LAYERS  per-layer pixel-on flags
- layer_color  in  NUM_LAYERS*COLOR_W  flattened colours; layer i is at [i*COLOR_W +: COLOR_W]
- cfg_we  in  1  configuration write strobe
- cfg_layer  in  PRIO_W  target layer index
- cfg_prio  in  PRIO_W  new priority; 0 is highest
- cfg_en  in  1  new layer enable
- rgb  out  COLOR_W  composited pixel
- rgb_valid  out  1  video_on delayed to align with rgb
- collision  out  NUM_LAYERS*NUM_LAYERS  bit [i*NUM_LAYERS+j], i<j, set if layers i and j overlapped last frame; all other bits always 0
- collision_valid  out  1  one-cycle pulse when collision updates

## Operation
- Configuration uses two register sets: shadow and active. Each holds prio[i] and en[i]. Reset value for both sets: prio[i]=i, en[i]=1.
- A cfg_we write goes to shadow[cfg_layer]. A cfg_layer value ≥ NUM_LAYERS is ignored.
- On frame_start: active ← shadow. A cfg_we in the same cycle is written through, so the copied value includes it.
- Stage 1 registers:
  - on_q = layer_on & active.en & {NUM_LAYERS{video_on}}
  - colours
  - video_on
- Stage 2 selects a winner among set bits of on_q:
  - lowest prio wins
  - ties go to the lowest layer index (duplicate priorities are legal)
- Stage 2 output:
  - rgb = winner colour
  - rgb = BACKDROP if no bit of on_q is set
  - rgb = 0 if the stage-1 video_on is 0
- Collision accumulator (when COLLISION_EN is defined):
  - acc[i][j] |= on_q[i] & on_q[j] for i<j
  - Overlap counts only for enabled layers.
- On frame_start:
  - collision ← acc OR the current-cycle contribution
  - acc ← 0
  - collision_valid pulses the next cycle, aligned with the new collision value
- Reset mid-frame: all outputs go to 0 immediately; partial-frame acc is discarded.

## Timing
- Latency is 2 cycles, from layer_on/layer_color/video_on to rgb/rgb_valid. Throughput is one pixel per cycle, with no stalls.
- Reset values:
  - rgb=0, rgb_valid=0, collision=0, collision_valid=0
  - pipeline registers = 0
  - config registers at the defaults above
- A cfg write in cycle t affects rgb starting with the pixel presented in the cycle after the next frame_start.
- collision is stable for a whole frame. It changes only on the edge after a frame_start cycle.
- Back-to-back frame_start pulses are legal. The second pulse publishes only what accumulated between the two pulses.

## Configuration
- Macro: `TANKWAR_COLLISION_EN`.
- Defined: accumulator and collision logic are present, as described above.
- Undefined:
  - accumulator is absent
  - collision is tied to 0
  - collision_valid still pulses one cycle after frame_start
  - rgb behaviour is identical in both builds

## Structure
- Shared package `tankwar_pkg`:
  - COLOR_W_DEF = 12
  - typedef color_t (logic [11:0])
  - constant BLACK = 12'h000
  - default layer-priority constants for bullet, tank1, tank2 and background
- Sub-module `layer_prio_arbiter`: combinational arg-min over (prio, index) for the set bits of on_q. It outputs a valid flag and the winner index, and is parametrised by NUM_LAYERS. The compositor registers its result.

## Test plan
- **Reset defaults.** Reset, then video_on=1, layer_on=4'b1010, L1=12'hF00, L3=12'h0F0 → rgb=12'hF00 two cycles later, rgb_valid=1.
- **Blanking and backdrop.**
  - video_on=0 with any layer_on → rgb=0, rgb_valid=0.
  - video_on=1, layer_on=0 → rgb=BACKDROP.
- **Frame-synchronous priority.** Write prio[3]=0, prio[1]=2 mid-frame → output still F00 until frame_start, then rgb=12'h0F0 for the same inputs.
- **Tie and disable.**
  - prio[0]=prio[2]=1 with both on → layer 0 wins.
  - cfg_en=0 for layer 0, then frame_start → layer 2 wins.
- **Collision.** During a frame, layers 0&2 overlap once and layers 1&3 never overlap → after frame_start, collision bit 2 = 1, bit 7 = 0, collision_valid pulses once. The next frame with no overlap reports all zeros.
- **Async reset mid-frame.** Assert reset with acc nonzero → outputs are 0 immediately. After release and frame_start, collision=0.
